// File: rtl/instr_decode.sv
// instr_decode: ARM instruction decoder stage with a two-entry elastic buffer.
// The buffer has an output register and one skid entry. Each fetched word is
// decoded on acceptance and appears on out_* one cycle later.
// Optional feature macro: BX_DECODE_EN. When it is defined, the BX pattern
// decodes as a branch-exchange. When it is undefined, that pattern is undefined.
module instr_decode (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic        in_ready,
   input  logic        flush,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [3:0]  out_cc,
   output logic [7:0]  out_alu_sel,
   output logic [3:0]  out_rn,
   output logic [3:0]  out_rm,
   output logic [3:0]  out_rd,
   output logic [31:0] out_imm,
   output logic [31:0] out_pc8,
   output logic        out_use_imm,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_undef
);

   typedef struct packed {
      logic [3:0]  cc;
      logic [7:0]  alu_sel;
      logic [3:0]  rn;
      logic [3:0]  rm;
      logic [3:0]  rd;
      logic [31:0] imm;
      logic [31:0] pc8;
      logic        use_imm;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        undef;
   } dec_t;

   localparam dec_t DEC_RESET = '{cc: 4'hE, alu_sel: 8'hFF, rn: 4'h0, rm: 4'h0,
                                  rd: 4'h0, imm: 32'h0, pc8: 32'h0, use_imm: 1'b0,
                                  reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                  undef: 1'b0};

   // Decode a single word. Any undefined encoding collapses to alu_sel=FF
   // with all enables clear. cc and pc8 are still carried for that word.
   function automatic dec_t decode(input logic [31:0] instr, input logic [31:0] pc);
      dec_t        d;
      logic [31:0] imm8z;
      logic [4:0]  rot;
      logic [3:0]  opc;
      logic        bad;
      d       = '0;
      d.cc    = instr[31:28];
      d.pc8   = pc + 32'd8;
      imm8z   = {24'd0, instr[7:0]};
      rot     = {instr[11:8], 1'b0};
      opc     = instr[24:21];
      bad     = 1'b0;
      if (instr[31:28] == 4'hF) begin
         bad = 1'b1;
      end else if (instr[27:4] == 24'h12FFF1) begin
`ifdef BX_DECODE_EN
         d.alu_sel = 8'h12;
         d.rm      = instr[3:0];
`else
         bad = 1'b1;
`endif
      end else if (instr[27:26] == 2'b00) begin
         if (!instr[25] && (instr[11:4] != 8'h00)) begin
            bad = 1'b1;
         end else begin
            d.alu_sel   = {2'b00, instr[25] & (opc == 4'hD), instr[24:20]};
            d.use_imm   = instr[25];
            d.reg_write = (opc[3:2] != 2'b10);
            d.rn        = instr[19:16];
            d.rd        = instr[15:12];
            if (instr[25])
               d.imm = (imm8z >> rot) | (imm8z << (6'd32 - {1'b0, rot}));
            else
               d.rm = instr[3:0];
         end
      end else if (instr[27:26] == 2'b01) begin
         if (instr[25]) begin
            bad = 1'b1;
         end else begin
            d.alu_sel   = instr[27:20];
            d.imm       = {20'd0, instr[11:0]};
            d.use_imm   = 1'b1;
            d.mem_read  = instr[20];
            d.mem_write = ~instr[20];
            d.reg_write = instr[20];
            d.rn        = instr[19:16];
            d.rd        = instr[15:12];
         end
      end else if (instr[27:25] == 3'b101) begin
         // The branch offset is an immediate operand. A link writes r14.
         d.alu_sel   = instr[27:20];
         d.imm       = {{6{instr[23]}}, instr[23:0], 2'b00};
         d.use_imm   = 1'b1;
         d.reg_write = instr[24];
         d.rd        = instr[24] ? 4'hE : 4'h0;
      end else begin
         bad = 1'b1;
      end
      if (bad) begin
         d         = '0;
         d.cc      = instr[31:28];
         d.pc8     = pc + 32'd8;
         d.alu_sel = 8'hFF;
         d.undef   = 1'b1;
      end
      return d;
   endfunction

   dec_t out_q;
   dec_t skid_q;
   logic skid_valid;
   logic accept;
   logic pop;
   dec_t in_dec;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;
   assign in_dec = decode(in_instr, in_pc);

   // Elastic buffer. The skid entry fills only while the output register is held.
   // in_ready is registered as the inverse of the next skid occupancy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
         out_q      <= DEC_RESET;
         skid_q     <= DEC_RESET;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else if (!out_valid || pop) begin
         if (skid_valid) begin
            out_q      <= skid_q;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
         end else if (accept) begin
            out_q      <= in_dec;
            out_valid  <= 1'b1;
         end else begin
            out_valid  <= 1'b0;
         end
      end else if (accept) begin
         skid_q     <= in_dec;
         skid_valid <= 1'b1;
         in_ready   <= 1'b0;
      end
   end

   assign out_cc        = out_q.cc;
   assign out_alu_sel   = out_q.alu_sel;
   assign out_rn        = out_q.rn;
   assign out_rm        = out_q.rm;
   assign out_rd        = out_q.rd;
   assign out_imm       = out_q.imm;
   assign out_pc8       = out_q.pc8;
   assign out_use_imm   = out_q.use_imm;
   assign out_reg_write = out_q.reg_write;
   assign out_mem_read  = out_q.mem_read;
   assign out_mem_write = out_q.mem_write;
   assign out_undef     = out_q.undef;

endmodule
